// File: rtl/config_port_arbiter.sv
// Arbitrates the eFPGA configuration write port between two byte-stream sources.
// Each session: sync-word hunt, 32-bit big-endian length header, then packed payload words.
module config_port_arbiter #(
  parameter logic [31:0] SYNC_WORD      = 32'hFAB0_FAB1,
  parameter logic [31:0] MAX_WORDS      = 32'd65536,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_200_000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [7:0]  src0_data_i,
  input  logic        src0_valid_i,
  output logic        src0_ready_o,
  input  logic [7:0]  src1_data_i,
  input  logic        src1_valid_i,
  output logic        src1_ready_o,
  output logic [31:0] write_data_o,
  output logic        write_strobe_o,
  output logic [1:0]  grant_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  typedef enum logic [1:0] {IDLE, SYNC, LEN, LOAD} state_t;

  state_t      state, state_n;
  logic [1:0]  grant_n, cnt, cnt_n;
  logic [31:0] shift, shift_n, rem, rem_n, wdata_n, shifted;
  logic [23:0] idle_cnt, idle_n;
  logic        strobe_n, done_n, error_n;
  logic        active, sel_valid, accept;
  logic [7:0]  sel_data;

  assign active       = (state != IDLE);
  assign busy_o       = active;
  assign src0_ready_o = active & grant_o[0];
  assign src1_ready_o = active & grant_o[1];
  assign sel_data     = grant_o[1] ? src1_data_i : src0_data_i;
  assign sel_valid    = (grant_o[0] & src0_valid_i) | (grant_o[1] & src1_valid_i);
  assign accept       = active & sel_valid;
  // One shift register serves as sync window, length collector and word packer.
  assign shifted      = {shift[23:0], sel_data};

  always_comb begin
    state_n  = state;
    grant_n  = grant_o;
    shift_n  = shift;
    cnt_n    = cnt;
    rem_n    = rem;
    wdata_n  = write_data_o;
    strobe_n = 1'b0;
    done_n   = 1'b0;
    error_n  = 1'b0;
    idle_n   = active ? idle_cnt + 24'd1 : 24'd0;

    if (!active) begin
      // Clearing the window here prevents stale bytes from faking a sync match.
      shift_n = 32'd0;
      cnt_n   = 2'd0;
      rem_n   = 32'd0;
      if (src0_valid_i) begin
        grant_n = 2'b01;
        state_n = SYNC;
      end else if (src1_valid_i) begin
        grant_n = 2'b10;
        state_n = SYNC;
      end else begin
        grant_n = 2'b00;
      end
    end else if (accept) begin
      idle_n  = 24'd0;
      shift_n = shifted;
      case (state)
        SYNC: begin
          if (shifted == SYNC_WORD) begin
            state_n = LEN;
            cnt_n   = 2'd0;
          end
        end
        LEN: begin
          cnt_n = cnt + 2'd1;
          if (cnt == 2'd3) begin
            if (shifted == 32'd0) begin
              done_n  = 1'b1;
              state_n = IDLE;
              grant_n = 2'b00;
            end else if (shifted > MAX_WORDS) begin
              error_n = 1'b1;
              state_n = IDLE;
              grant_n = 2'b00;
            end else begin
              rem_n   = shifted;
              state_n = LOAD;
            end
          end
        end
        default: begin
          cnt_n = cnt + 2'd1;
          if (cnt == 2'd3) begin
            wdata_n  = shifted;
            strobe_n = 1'b1;
            if (rem != 32'd0) rem_n = rem - 32'd1;
            if (rem == 32'd1) begin
              done_n  = 1'b1;
              state_n = IDLE;
              grant_n = 2'b00;
            end
          end
        end
      endcase
    end else if (idle_cnt == TIMEOUT_CYCLES - 24'd1) begin
      error_n = 1'b1;
      state_n = IDLE;
      grant_n = 2'b00;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state          <= IDLE;
      grant_o        <= 2'b00;
      shift          <= 32'd0;
      cnt            <= 2'd0;
      rem            <= 32'd0;
      idle_cnt       <= 24'd0;
      write_data_o   <= 32'd0;
      write_strobe_o <= 1'b0;
      done_o         <= 1'b0;
      error_o        <= 1'b0;
    end else begin
      state          <= state_n;
      grant_o        <= grant_n;
      shift          <= shift_n;
      cnt            <= cnt_n;
      rem            <= rem_n;
      idle_cnt       <= idle_n;
      write_data_o   <= wdata_n;
      write_strobe_o <= strobe_n;
      done_o         <= done_n;
      error_o        <= error_n;
    end
  end

endmodule

// File: tb/tb_config_port_arbiter.sv
// Directed bench for config_port_arbiter: sessions, arbitration, header edge cases, timeout, reset.
module tb_config_port_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [7:0]  src0_data_i, src1_data_i;
  logic        src0_valid_i, src1_valid_i;
  logic        src0_ready_o, src1_ready_o;
  logic [31:0] write_data_o;
  logic        write_strobe_o, busy_o, done_o, error_o;
  logic [1:0]  grant_o;

  config_port_arbiter #(.TIMEOUT_CYCLES(24'd100)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .src0_data_i(src0_data_i), .src0_valid_i(src0_valid_i), .src0_ready_o(src0_ready_o),
    .src1_data_i(src1_data_i), .src1_valid_i(src1_valid_i), .src1_ready_o(src1_ready_o),
    .write_data_o(write_data_o), .write_strobe_o(write_strobe_o), .grant_o(grant_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          cyc_last = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  logic        src1_rdy_seen = 1'b0;
  logic        both_seen = 1'b0;
  logic [31:0] strobes[$];
  logic [7:0]  tx[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (write_strobe_o) strobes.push_back(write_data_o);
    if (done_o) done_cnt++;
    if (error_o) err_cnt++;
    if (done_o && error_o) both_seen = 1'b1;
    if (src1_ready_o) src1_rdy_seen = 1'b1;
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic clear_log();
    strobes.delete();
    done_cnt = 0;
    err_cnt = 0;
    src1_rdy_seen = 1'b0;
  endtask

  // Streams tx back-to-back on one source; returns 1 time unit after the last handshake edge.
  task automatic send_tx(input int src);
    for (int i = 0; i < tx.size(); i++) begin
      int w;
      w = 0;
      if (src == 0) begin src0_data_i = tx[i]; src0_valid_i = 1'b1; end
      else          begin src1_data_i = tx[i]; src1_valid_i = 1'b1; end
      while (!((src == 0) ? src0_ready_o : src1_ready_o) && w < 20) begin
        step(1);
        w++;
      end
      n_checks++;
      if (w >= 20) begin
        n_fail++;
        $display("FAIL send_tx_ready: src%0d byte %0d not accepted, ready=0 expected 1", src, i);
        src0_valid_i = 1'b0;
        src1_valid_i = 1'b0;
        return;
      end
      step(1);
      cyc_last = cyc;
    end
    if (src == 0) src0_valid_i = 1'b0;
    else          src1_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    step(2);
    reset_i = 1'b0;
    n_checks++;
    if ({write_data_o, write_strobe_o, grant_o, busy_o, done_o, error_o} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {write_data_o, write_strobe_o, grant_o, busy_o, done_o, error_o});
    end
    n_checks++;
    if ({src0_ready_o, src1_ready_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 00", {src0_ready_o, src1_ready_o});
    end
  endtask

  task automatic test_basic();
    clear_log();
    src0_data_i = 8'h11;
    src0_valid_i = 1'b1;
    step(1);
    n_checks++;
    if (grant_o !== 2'b01) begin n_fail++; $display("FAIL basic_grant: got %b expected 01", grant_o); end
    tx = '{8'h11, 8'hFA, 8'hB0, 8'hFA, 8'hB1, 8'h00, 8'h00, 8'h00, 8'h02,
           8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
    send_tx(0);
    n_checks++;
    if ({write_strobe_o, done_o, src0_ready_o, busy_o} !== 4'b1100) begin
      n_fail++;
      $display("FAIL basic_final: strobe,done,ready,busy=%b expected 1100",
               {write_strobe_o, done_o, src0_ready_o, busy_o});
    end
    step(3);
    n_checks++;
    if (strobes.size() !== 2) begin
      n_fail++; $display("FAIL basic_nstrobe: got %0d expected 2", strobes.size());
    end else begin
      n_checks++;
      if (strobes[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_word0: got %h expected deadbeef", strobes[0]); end
      n_checks++;
      if (strobes[1] !== 32'h01020304) begin n_fail++; $display("FAIL basic_word1: got %h expected 01020304", strobes[1]); end
    end
    n_checks++;
    if (done_cnt !== 1 || src1_rdy_seen !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_src1: done=%0d src1_ready_seen=%b expected 1,0", done_cnt, src1_rdy_seen);
    end
  endtask

  task automatic test_simultaneous();
    clear_log();
    src0_data_i = 8'hFA; src0_valid_i = 1'b1;
    src1_data_i = 8'hFA; src1_valid_i = 1'b1;
    step(1);
    n_checks++;
    if (grant_o !== 2'b01) begin n_fail++; $display("FAIL simul_grant0: got %b expected 01", grant_o); end
    tx = '{8'hFA, 8'hB0, 8'hFA, 8'hB1, 8'h00, 8'h00, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    send_tx(0);
    n_checks++;
    if ({done_o, grant_o, src1_ready_o, src1_rdy_seen} !== 5'b10000) begin
      n_fail++;
      $display("FAIL simul_src0_end: done,grant,src1_ready,seen=%b expected 10000",
               {done_o, grant_o, src1_ready_o, src1_rdy_seen});
    end
    step(1);
    n_checks++;
    if (grant_o !== 2'b10) begin n_fail++; $display("FAIL simul_grant1: got %b expected 10", grant_o); end
    tx = '{8'hFA, 8'hB0, 8'hFA, 8'hB1, 8'h00, 8'h00, 8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    send_tx(1);
    step(3);
    n_checks++;
    if (strobes.size() !== 2) begin
      n_fail++; $display("FAIL simul_nstrobe: got %0d expected 2", strobes.size());
    end else begin
      n_checks++;
      if (strobes[0] !== 32'h11223344) begin n_fail++; $display("FAIL simul_word0: got %h expected 11223344", strobes[0]); end
      n_checks++;
      if (strobes[1] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL simul_word1: got %h expected cafef00d", strobes[1]); end
    end
    n_checks++;
    if (done_cnt !== 2) begin n_fail++; $display("FAIL simul_done: got %0d expected 2", done_cnt); end
  endtask

  task automatic test_zero_len();
    clear_log();
    tx = '{8'hFA, 8'hB0, 8'hFA, 8'hB1, 8'h00, 8'h00, 8'h00, 8'h00};
    send_tx(0);
    n_checks++;
    if ({done_o, error_o, write_strobe_o, busy_o} !== 4'b1000) begin
      n_fail++; $display("FAIL zero_len: done,error,strobe,busy=%b expected 1000",
                         {done_o, error_o, write_strobe_o, busy_o});
    end
    step(3);
    n_checks++;
    if (strobes.size() !== 0 || done_cnt !== 1) begin
      n_fail++; $display("FAIL zero_len_log: strobes=%0d done=%0d expected 0,1", strobes.size(), done_cnt);
    end
  endtask

  task automatic test_too_long();
    clear_log();
    tx = '{8'hFA, 8'hB0, 8'hFA, 8'hB1, 8'h00, 8'h01, 8'h00, 8'h01};
    send_tx(0);
    n_checks++;
    if ({error_o, done_o, grant_o, busy_o} !== 5'b10000) begin
      n_fail++; $display("FAIL too_long: error,done,grant,busy=%b expected 10000",
                         {error_o, done_o, grant_o, busy_o});
    end
    step(3);
    n_checks++;
    if (strobes.size() !== 0 || err_cnt !== 1) begin
      n_fail++; $display("FAIL too_long_log: strobes=%0d errors=%0d expected 0,1", strobes.size(), err_cnt);
    end
  endtask

  task automatic test_timeout();
    int w;
    clear_log();
    tx = '{8'hFA, 8'hB0, 8'hFA, 8'hB1, 8'h00, 8'h00, 8'h00, 8'h03,
           8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
    send_tx(0);
    w = 0;
    while (!error_o && w < 150) begin
      step(1);
      w++;
    end
    n_checks++;
    if (cyc - cyc_last !== 100) begin
      n_fail++; $display("FAIL timeout_delay: error after %0d cycles expected 100", cyc - cyc_last);
    end
    n_checks++;
    if ({grant_o, busy_o, done_o} !== 4'b0000) begin
      n_fail++; $display("FAIL timeout_state: grant,busy,done=%b expected 0000", {grant_o, busy_o, done_o});
    end
    step(3);
    n_checks++;
    if (strobes.size() !== 1) begin
      n_fail++; $display("FAIL timeout_nstrobe: got %0d expected 1", strobes.size());
    end else begin
      n_checks++;
      if (strobes[0] !== 32'hA1A2A3A4) begin n_fail++; $display("FAIL timeout_word: got %h expected a1a2a3a4", strobes[0]); end
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    tx = '{8'hFA, 8'hB0, 8'hFA, 8'hB1, 8'h00, 8'h00, 8'h00, 8'h02, 8'hAA, 8'hBB};
    send_tx(0);
    reset_i = 1'b1;
    step(1);
    reset_i = 1'b0;
    n_checks++;
    if ({write_data_o, write_strobe_o, grant_o, busy_o, done_o, error_o, src0_ready_o, src1_ready_o} !== 40'd0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got %h expected 0",
                         {write_data_o, write_strobe_o, grant_o, busy_o, done_o, error_o, src0_ready_o, src1_ready_o});
    end
    step(2);
    n_checks++;
    if (strobes.size() !== 0) begin n_fail++; $display("FAIL reset_mid_partial: strobes=%0d expected 0", strobes.size()); end
    tx = '{8'hFA, 8'hB0, 8'hFA, 8'hB1, 8'h00, 8'h00, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    send_tx(0);
    step(3);
    n_checks++;
    if (strobes.size() !== 1 || done_cnt !== 1) begin
      n_fail++; $display("FAIL reset_mid_fresh: strobes=%0d done=%0d expected 1,1", strobes.size(), done_cnt);
    end else begin
      n_checks++;
      if (strobes[0] !== 32'h12345678) begin n_fail++; $display("FAIL reset_mid_word: got %h expected 12345678", strobes[0]); end
    end
  endtask

  initial begin
    reset_i = 1'b0;
    src0_data_i = 8'h00; src0_valid_i = 1'b0;
    src1_data_i = 8'h00; src1_valid_i = 1'b0;
    #1;
    test_reset();
    step(2);
    test_basic();
    step(2);
    test_simultaneous();
    step(2);
    test_zero_len();
    step(2);
    test_too_long();
    step(2);
    test_timeout();
    step(2);
    test_reset_mid();
    n_checks++;
    if (both_seen !== 1'b0) begin n_fail++; $display("FAIL done_error_overlap: got 1 expected 0"); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
